// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder_pkg : shared FSM encoding and default operand width
// Revision: 1.0
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_adder_bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// half_adder / adder_bit : one-bit combinational adder cells
// Revision: 1.0
// ---------------------------------------------------------------------------
module half_adder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

module adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.x(a),    .y(b),   .sum(w_s0), .carry(w_c0));
  half_adder u_ha1 (.x(w_s0), .y(cin), .sum(sum),  .carry(w_c1));

  assign cout = w_c0 | w_c1;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder : bit-serial add/subtract, one result bit per clock, LSB first
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    count_q;
  logic             carry_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             load;
  logic             last;
  logic             bit_sum;
  logic             bit_cout;

  adder_bit u_adder_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (bit_sum),
    .cout (bit_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (count_q == LAST_COUNT) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    load = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    last = (state_q == ST_RUN) && (count_q == LAST_COUNT);
  end

  // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      count_q <= '0;
    end else if (state_q == ST_RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      s_q     <= {bit_sum, s_q[WIDTH-1:1]};
      carry_q <= bit_cout;
      count_q <= count_q + 1'b1;
      if (last) begin
        c_out_q <= bit_cout;
        ovf_q   <= carry_q ^ bit_cout;
      end
    end
  end

  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_adder : randomized and directed self-checking bench for serial_adder
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference: signed/unsigned integer arithmetic, packed as {ovf, c_out, s}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sb);
    int ux, uy, sx, sy, sr, ur;
    logic [W-1:0] rs;
    logic rc, ro;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    if (sb) begin
      ur = ux - uy;
      sr = sx - sy;
      rc = (ux >= uy);
    end else begin
      ur = ux + uy;
      sr = sx + sy;
      rc = (ur > 255);
    end
    rs = W'(ur);
    ro = (sr > 127) || (sr < -128);
    return {ro, rc, rs};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one op and run until done (bounded). lat counts cycles after the start cycle.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        output int lat, output int busy_cyc,
                        output logic [W-1:0] rs, output logic rc, output logic ro);
    a = ia; b = ib; sub = isub; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      tick;
      lat++;
    end
    rs = s; rc = c_out; ro = ovf;
  endtask

  task automatic test_reset;
    int lat, bc;
    logic [W-1:0] rs;
    logic rc, ro;
    rst = 1'b1; start = 1'b1; sub = 1'b0; a = 8'hAA; b = 8'h55;
    tick; tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== '0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b s=%h c_out=%b ovf=%b, need all 0",
               busy, done, s, c_out, ovf);
    end
    // start on the very first edge after reset release
    rst = 1'b0; start = 1'b1; a = 8'h21; b = 8'h13; sub = 1'b0;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL start_after_reset: busy=%b need 1", busy);
    end
    lat = 0;
    while (!done && lat < 40) begin tick; lat++; end
    checks++;
    if (done !== 1'b1 || s !== 8'h34) begin
      failures++;
      $display("FAIL start_after_reset_result: done=%b s=%h need done=1 s=34", done, s);
    end
    tick;
    run_op(8'h00, 8'h00, 1'b0, lat, bc, rs, rc, ro);
    tick;
  endtask

  task automatic test_directed;
    logic [W-1:0] va[4] = '{8'h0F, 8'hFF, 8'h7F, 8'h05};
    logic [W-1:0] vb[4] = '{8'h01, 8'h01, 8'h01, 8'h07};
    logic         vs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] es[4] = '{8'h10, 8'h00, 8'h80, 8'hFE};
    logic         ec[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         eo[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat, bc;
    logic [W-1:0] rs;
    logic rc, ro;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], lat, bc, rs, rc, ro);
      checks++;
      if (lat !== 9 || bc !== 8) begin
        failures++;
        $display("FAIL directed_latency[%0d]: lat=%0d busy_cycles=%0d need 9/8", i, lat, bc);
      end
      checks++;
      if (rs !== es[i] || rc !== ec[i] || ro !== eo[i]) begin
        failures++;
        $display("FAIL directed_result[%0d]: s=%h c=%b o=%b need s=%h c=%b o=%b",
                 i, rs, rc, ro, es[i], ec[i], eo[i]);
      end
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || s !== es[i] || c_out !== ec[i] || ovf !== eo[i]) begin
        failures++;
        $display("FAIL directed_hold[%0d]: done=%b busy=%b s=%h c=%b o=%b need 0/0/%h/%b/%b",
                 i, done, busy, s, c_out, ovf, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [W-1:0] ra, rb, rs;
    logic rsb, rc, ro;
    logic [W+1:0] exp;
    for (int i = 0; i < 24; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rsb = 1'($urandom_range(0, 1));
      exp = model(ra, rb, rsb);
      run_op(ra, rb, rsb, lat, bc, rs, rc, ro);
      checks++;
      if (lat !== 9 || {ro, rc, rs} !== exp) begin
        failures++;
        $display("FAIL random[%0d] %h %s %h: lat=%0d s=%h c=%b o=%b need lat=9 s=%h c=%b o=%b",
                 i, ra, rsb ? "-" : "+", rb, lat, rs, rc, ro, exp[W-1:0], exp[W], exp[W+1]);
      end
      if ($urandom_range(0, 1) == 1) tick;
    end
    tick;
  endtask

  task automatic test_start_in_run;
    int lat, bc;
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      if (lat == 3) begin a = 8'h00; b = 8'h00; start = 1'b1; end
      tick;
      start = 1'b0;
      lat++;
    end
    checks++;
    if (lat !== 9 || bc !== 8 || s !== 8'h46) begin
      failures++;
      $display("FAIL start_in_run: lat=%0d busy_cycles=%0d s=%h need 9/8/46", lat, bc, s);
    end
    tick;
  endtask

  task automatic test_rst_in_run;
    int lat, bc, pulses;
    logic [W-1:0] ra, rb, rs;
    logic rc, ro;
    logic [W+1:0] exp;
    a = 8'hC3; b = 8'h5A; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== '0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_run: busy=%b done=%b s=%h c=%b o=%b need all 0",
               busy, done, s, c_out, ovf);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      tick;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL rst_in_run_no_done: done pulses=%0d need 0", pulses);
    end
    ra = W'($urandom); rb = W'($urandom);
    exp = model(ra, rb, 1'b1);
    run_op(ra, rb, 1'b1, lat, bc, rs, rc, ro);
    checks++;
    if (lat !== 9 || {ro, rc, rs} !== exp) begin
      failures++;
      $display("FAIL rst_in_run_fresh: lat=%0d s=%h c=%b o=%b need 9 s=%h c=%b o=%b",
               lat, rs, rc, ro, exp[W-1:0], exp[W], exp[W+1]);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int lat, pulses;
    logic [W-1:0] a1, b1, a2, b2;
    logic [W+1:0] e1, e2;
    a1 = W'($urandom); b1 = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
    e1 = model(a1, b1, 1'b0);
    e2 = model(a2, b2, 1'b1);
    a = a1; b = b1; sub = 1'b0; start = 1'b1;
    tick;
    lat = 1;
    while (!done && lat < 40) begin tick; lat++; end
    checks++;
    if (lat !== 9 || {ovf, c_out, s} !== e1) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d s=%h c=%b o=%b need 9 s=%h c=%b o=%b",
               lat, s, c_out, ovf, e1[W-1:0], e1[W], e1[W+1]);
    end
    a = a2; b = b2; sub = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_idle: busy=%b done=%b need 1/0", busy, done);
    end
    lat = 1; pulses = 0;
    while (!done && lat < 40) begin tick; lat++; end
    if (done) pulses++;
    tick;
    if (done) pulses++;
    checks++;
    if (lat !== 9 || pulses !== 1 || {ovf, c_out, s} !== e2) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d pulses=%0d s=%h c=%b o=%b need 9/1 s=%h c=%b o=%b",
               lat, pulses, s, c_out, ovf, e2[W-1:0], e2[W], e2[W+1]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    test_reset;
    test_directed;
    test_random;
    test_start_in_run;
    test_rst_in_run;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 selects a+b, 1 selects a-b; sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH bits: first operand; sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH bits: second operand; sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-010 The block SHALL have port s, output, WIDTH bits: result.
REQ-011 The block SHALL have port c_out, output, 1 bit: final carry (for sub, 1 = no borrow).
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 In IDLE or DONE with start=1, the block SHALL load A<=a, B<=(sub ? ~b : b), carry<=sub, count<=0, and go to RUN.
REQ-015 In RUN, each cycle SHALL add A[0]+B[0]+carry in one full-adder bit cell, shift A and B right by one, shift the sum bit into the MSB of the result register, update carry, and increment count.
REQ-016 RUN SHALL last exactly WIDTH cycles; after the cycle with count=WIDTH-1, the FSM SHALL go to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unless start=1 (back-to-back, per REQ-014).
REQ-018 Latency SHALL be WIDTH+1 cycles from the edge that samples start to the first cycle with done=1 (9 cycles for WIDTH=8).
REQ-019 busy SHALL be 1 exactly in RUN.
REQ-020 start asserted in RUN SHALL be ignored, with no effect on the operation in flight.
REQ-021 s, c_out and ovf SHALL be valid when done=1 and SHALL hold their values until the next operation enters RUN.
REQ-022 During RUN, the s register SHALL hold partial data; s is undefined for consumers until done.
REQ-023 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, captured on the last RUN cycle.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH, with the carry discarded from s and reported on c_out.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL enter IDLE and clear busy, done, s, c_out, ovf, count and carry to 0.
REQ-026 rst SHALL take priority over start, including while in RUN, where the operation is aborted and done never pulses.
REQ-027 The block SHALL accept start on the first edge after rst is deasserted.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 The block SHALL contain one sub-module, adder_bit: a combinational full-adder cell built from two instances of the team's existing half-adder cell plus an OR of their carries.
REQ-030 count SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-031 The bench SHALL check a=0x0F, b=0x01, sub=0 -> after 9 cycles done=1, s=0x10, c_out=0, ovf=0.
REQ-032 The bench SHALL check a=0xFF, b=0x01, sub=0 -> s=0x00, c_out=1, ovf=0.
REQ-033 The bench SHALL check a=0x7F, b=0x01, sub=0 -> s=0x80, c_out=0, ovf=1; and a=0x05, b=0x07, sub=1 -> s=0xFE, c_out=0, ovf=0.
REQ-034 The bench SHALL check start re-pulsed with a=0x00, b=0x00 on cycle 3 of RUN for 0x12+0x34 -> ignored; s=0x46 at the original done time, busy high for exactly 8 cycles.
REQ-035 The bench SHALL check rst asserted on cycle 4 of RUN -> next cycle busy=0, s=0, no done pulse; a fresh start then completes normally.
REQ-036 The bench SHALL check start held high through DONE -> back-to-back operations with no IDLE cycle between them, each giving one done pulse.
